uart_rx_cfg: RTL and testbench

Configurable UART receiver that succeeds the fixed 8N1 receiver. It adds parametrised data width, run-time parity and stop-bit selection, and 3-sample majority voting with false-start rejection. It also adds break detection and a valid/ready output handshake with overrun reporting. It sits between the pad-side `rx_in` line and the byte consumer (FIFO or register bank) in the UART subsystem.

---
 rtl/uart_pkg.sv | 18 +
 rtl/uart_rx_cfg_if.sv | 18 +
 rtl/uart_rx_sampler.sv | 44 ++++
 rtl/uart_rx_cfg.sv | 132 +++++++++++++
 tb/tb_uart_rx_cfg.sv | 202 ++++++++++++++++++++
 5 files changed

// File: rtl/uart_pkg.sv
// uart_pkg: shared parity modes, receiver state encoding and default timing for the UART blocks
package uart_pkg;
    localparam int DEF_BAUD_DIV = 10416;
    localparam logic [1:0] PAR_NONE = 2'b00;
    localparam logic [1:0] PAR_EVEN = 2'b01;
    localparam logic [1:0] PAR_ODD  = 2'b10;
    typedef enum logic [2:0] {
        RX_IDLE,
        RX_START,
        RX_DATA,
        RX_PARITY,
        RX_STOP1,
        RX_STOP2
    } rx_state_t;
    function automatic logic par_on(input logic [1:0] mode);
        return mode == PAR_EVEN || mode == PAR_ODD;
    endfunction
endpackage

// File: rtl/uart_rx_cfg_if.sv
// uart_rx_cfg_if: received-word handshake between the receiver and its consumer
interface uart_rx_cfg_if #(parameter int DATA_BITS = 8) ();
    logic [DATA_BITS-1:0] rx_data;
    logic                 rx_valid;
    logic                 rx_ready;
    logic                 parity_err;
    logic                 frame_err;
    logic                 break_det;
    logic                 overrun;
    modport master (
        output rx_data, rx_valid, parity_err, frame_err, break_det, overrun,
        input  rx_ready
    );
    modport slave (
        input  rx_data, rx_valid, parity_err, frame_err, break_det, overrun,
        output rx_ready
    );
endinterface

// File: rtl/uart_rx_sampler.sv
// uart_rx_sampler: line synchroniser, falling-edge detect, bit-phase counter and 3-sample majority vote
module uart_rx_sampler #(
    parameter int BAUD_DIV  = 16,
    parameter int MID_POINT = BAUD_DIV / 2
) (
    input  logic clk,
    input  logic arst,
    input  logic rx_in,
    input  logic clr,
    output logic start_edge,
    output logic bit_valid,
    output logic bit_val
);
    localparam int CW = $clog2(BAUD_DIV);
    logic          sync1, line_s, line_d, smp_a, smp_b;
    logic [CW-1:0] cnt;
    // two-flop synchroniser plus one delayed copy for edge detection; idle-high line
    always_ff @(posedge clk or posedge arst) begin
        if (arst) begin
            sync1  <= 1'b1;
            line_s <= 1'b1;
            line_d <= 1'b1;
        end else begin
            sync1  <= rx_in;
            line_s <= sync1;
            line_d <= line_s;
        end
    end
    // bit-phase counter: the detect cycle counts as phase 0, so the third sample lands on MID_POINT+1
    always_ff @(posedge clk or posedge arst) begin
        if (arst) begin
            cnt   <= '0;
            smp_a <= 1'b1;
            smp_b <= 1'b1;
        end else begin
            cnt <= clr ? CW'(1) : (cnt == CW'(BAUD_DIV - 1) ? '0 : cnt + 1'b1);
            if (cnt == CW'(MID_POINT - 1)) smp_a <= line_s;
            if (cnt == CW'(MID_POINT)) smp_b <= line_s;
        end
    end
    assign start_edge = line_d & ~line_s;
    assign bit_valid  = cnt == CW'(MID_POINT + 1);
    assign bit_val    = (smp_a & smp_b) | (smp_a & line_s) | (smp_b & line_s);
endmodule

// File: rtl/uart_rx_cfg.sv
// uart_rx_cfg: configurable UART receiver with parity/stop selection, break detect and valid/ready output
module uart_rx_cfg
    import uart_pkg::*;
#(
    parameter int BAUD_DIV  = DEF_BAUD_DIV,
    parameter int MID_POINT = BAUD_DIV / 2,
    parameter int DATA_BITS = 8
) (
    input  logic       clk,
    input  logic       arst,
    input  logic       rx_en,
    input  logic       rx_in,
    input  logic [1:0] parity_mode,
    input  logic       two_stop,
    output logic       rx_busy,
    uart_rx_cfg_if.master bus
);
    localparam int IW = $clog2(DATA_BITS);
    rx_state_t            state;
    logic [1:0]           pm_l;
    logic                 two_l, par_acc, zero_l, pe_l, fe_l, brk_l;
    logic [DATA_BITS-1:0] shreg;
    logic [IW-1:0]        bit_idx;
    logic                 start_edge, bit_valid, bit_val, start_take;
    logic                 last, fin_fe, fin_bk;

    uart_rx_sampler #(.BAUD_DIV(BAUD_DIV), .MID_POINT(MID_POINT)) sampler (
        .clk(clk),
        .arst(arst),
        .rx_in(rx_in),
        .clr(start_take),
        .start_edge(start_edge),
        .bit_valid(bit_valid),
        .bit_val(bit_val)
    );

    assign start_take = state == RX_IDLE && rx_en && start_edge;

    // final stop decision and the flags it completes; break is fixed once STOP1 is decided
    always_comb begin
        last   = bit_valid && (state == RX_STOP2 || (state == RX_STOP1 && !two_l));
        fin_fe = (state == RX_STOP1) ? ~bit_val : (fe_l | ~bit_val);
        fin_bk = (state == RX_STOP1) ? (zero_l & ~bit_val) : brk_l;
    end

    // frame FSM: settings latched at start, data shifted LSB first, flags accumulated per bit
    always_ff @(posedge clk or posedge arst) begin
        if (arst) begin
            state   <= RX_IDLE;
            rx_busy <= 1'b0;
            pm_l    <= PAR_NONE;
            two_l   <= 1'b0;
            shreg   <= '0;
            bit_idx <= '0;
            par_acc <= 1'b0;
            zero_l  <= 1'b1;
            pe_l    <= 1'b0;
            fe_l    <= 1'b0;
            brk_l   <= 1'b0;
        end else begin
            case (state)
                RX_IDLE: if (start_take) begin
                    state   <= RX_START;
                    rx_busy <= 1'b1;
                    pm_l    <= parity_mode;
                    two_l   <= two_stop;
                    bit_idx <= '0;
                    par_acc <= 1'b0;
                    zero_l  <= 1'b1;
                    pe_l    <= 1'b0;
                    fe_l    <= 1'b0;
                    brk_l   <= 1'b0;
                end
                RX_START: if (bit_valid) begin
                    state   <= bit_val ? RX_IDLE : RX_DATA;
                    rx_busy <= ~bit_val;
                end
                RX_DATA: if (bit_valid) begin
                    shreg   <= {bit_val, shreg[DATA_BITS-1:1]};
                    par_acc <= par_acc ^ bit_val;
                    zero_l  <= zero_l & ~bit_val;
                    bit_idx <= bit_idx + 1'b1;
                    if (bit_idx == IW'(DATA_BITS - 1)) state <= par_on(pm_l) ? RX_PARITY : RX_STOP1;
                end
                RX_PARITY: if (bit_valid) begin
                    pe_l   <= (par_acc ^ bit_val) != (pm_l == PAR_ODD);
                    zero_l <= zero_l & ~bit_val;
                    state  <= RX_STOP1;
                end
                RX_STOP1: if (bit_valid) begin
                    fe_l    <= ~bit_val;
                    brk_l   <= zero_l & ~bit_val;
                    state   <= two_l ? RX_STOP2 : RX_IDLE;
                    rx_busy <= two_l;
                end
                RX_STOP2: if (bit_valid) begin
                    state   <= RX_IDLE;
                    rx_busy <= 1'b0;
                end
                default: begin
                    state   <= RX_IDLE;
                    rx_busy <= 1'b0;
                end
            endcase
        end
    end

    // output word register: load when empty or being accepted, otherwise drop the frame and flag overrun
    always_ff @(posedge clk or posedge arst) begin
        if (arst) begin
            bus.rx_data    <= '0;
            bus.rx_valid   <= 1'b0;
            bus.parity_err <= 1'b0;
            bus.frame_err  <= 1'b0;
            bus.break_det  <= 1'b0;
            bus.overrun    <= 1'b0;
        end else begin
            bus.overrun <= 1'b0;
            if (last && (!bus.rx_valid || bus.rx_ready)) begin
                bus.rx_data    <= shreg;
                bus.rx_valid   <= 1'b1;
                bus.parity_err <= pe_l;
                bus.frame_err  <= fin_fe;
                bus.break_det  <= fin_bk;
            end else if (last) begin
                bus.overrun <= 1'b1;
            end else if (bus.rx_valid && bus.rx_ready) begin
                bus.rx_valid <= 1'b0;
            end
        end
    end
endmodule

// File: tb/tb_uart_rx_cfg.sv
// tb_uart_rx_cfg: directed frames on a precomputed line waveform, outputs snapshotted every cycle
module tb_uart_rx_cfg;
    import uart_pkg::*;
    localparam int BD = 16;
    localparam int LEN = 600;
    logic       clk = 1'b0;
    logic       arst = 1'b1;
    logic       rx_en = 1'b1;
    logic       rx_in = 1'b1;
    logic [1:0] parity_mode = PAR_NONE;
    logic       two_stop = 1'b0;
    logic       rx_busy;
    int         total = 0;
    int         bad = 0;
    logic        line [LEN];
    logic [13:0] snap [LEN];

    uart_rx_cfg_if #(.DATA_BITS(8)) bus ();

    uart_rx_cfg #(.BAUD_DIV(BD), .MID_POINT(8), .DATA_BITS(8)) dut (
        .clk(clk),
        .arst(arst),
        .rx_en(rx_en),
        .rx_in(rx_in),
        .parity_mode(parity_mode),
        .two_stop(two_stop),
        .rx_busy(rx_busy),
        .bus(bus)
    );

    always #5 clk = ~clk;

    // snapshot layout: [7:0] data, 8 valid, 9 parity_err, 10 frame_err, 11 break, 12 overrun, 13 busy
    function automatic logic [13:0] cur();
        return {rx_busy, bus.overrun, bus.break_det, bus.frame_err, bus.parity_err, bus.rx_valid, bus.rx_data};
    endfunction

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic idle_line();
        for (int i = 0; i < LEN; i++) line[i] = 1'b1;
    endtask

    task automatic put_bit(input int at, input logic v);
        for (int j = 0; j < BD; j++) line[at + j] = v;
    endtask

    task automatic put_frame(input int at, input logic [7:0] d, input bit pen, input logic pb,
                             input bit two, input logic s2v);
        int o;
        o = at;
        put_bit(o, 1'b0);
        o += BD;
        for (int b = 0; b < 8; b++) begin
            put_bit(o, d[b]);
            o += BD;
        end
        if (pen) begin
            put_bit(o, pb);
            o += BD;
        end
        put_bit(o, 1'b1);
        o += BD;
        if (two) put_bit(o, s2v);
    endtask

    // offset t snapshot is taken before line[t] is driven; a start driven at offset 0 gives cycle E at offset 2
    task automatic run(input int len);
        for (int t = 0; t < len; t++) begin
            @(negedge clk);
            snap[t] = cur();
            rx_in = line[t];
        end
    endtask

    function automatic int ones(input int b, input int lo, input int hi);
        int n;
        n = 0;
        for (int t = lo; t <= hi; t++) n += int'(snap[t][b]);
        return n;
    endfunction

    initial begin
        bus.rx_ready = 1'b1;
        repeat (3) @(negedge clk);
        chk("reset_state", cur(), 0);
        arst = 1'b0;
        repeat (5) @(negedge clk);
        chk("after_reset", cur(), 0);

        idle_line();
        put_frame(0, 8'hA5, 0, 0, 0, 0);
        run(200);
        chk("a5_busy_e", snap[2][13], 0);
        chk("a5_busy_e1", snap[3][13], 1);
        chk("a5_busy_last", snap[155][13], 1);
        chk("a5_valid_early", snap[155][8], 0);
        chk("a5_word", snap[156][11:0], 12'h1A5);
        chk("a5_busy_done", snap[156][13], 0);
        chk("a5_valid_drop", snap[157][8], 0);

        parity_mode = PAR_EVEN;
        idle_line();
        put_frame(0, 8'h07, 1, 0, 0, 0);
        run(200);
        chk("even_p0_valid", snap[172][8], 1);
        chk("even_p0_perr", snap[172][9], 1);
        idle_line();
        put_frame(0, 8'h07, 1, 1, 0, 0);
        run(200);
        chk("even_p1_perr", snap[172][9], 0);
        chk("even_p1_data", snap[172][7:0], 8'h07);
        parity_mode = PAR_ODD;
        idle_line();
        put_frame(0, 8'h07, 1, 0, 0, 0);
        run(200);
        chk("odd_p0_perr", snap[172][9], 0);
        idle_line();
        put_frame(0, 8'h07, 1, 1, 0, 0);
        run(200);
        chk("odd_p1_perr", snap[172][9], 1);
        parity_mode = PAR_NONE;

        idle_line();
        for (int i = 0; i < 3; i++) line[i] = 1'b0;
        run(60);
        chk("glitch_busy_mid", snap[10][13], 1);
        chk("glitch_busy_off", snap[12][13], 0);
        chk("glitch_no_valid", ones(8, 0, 59), 0);

        idle_line();
        put_frame(0, 8'hA5, 0, 0, 0, 0);
        line[3 * BD + 8] = ~line[3 * BD + 8];
        line[2 * BD + 8] = ~line[2 * BD + 8];
        run(200);
        chk("spike_word", snap[156][11:0], 12'h1A5);

        two_stop = 1'b1;
        idle_line();
        put_frame(0, 8'h5A, 0, 0, 1, 0);
        run(200);
        chk("stop2_valid_late", snap[156][8], 0);
        chk("stop2_word", snap[172][11:8], 4'h5);
        chk("stop2_data", snap[172][7:0], 8'h5A);
        two_stop = 1'b0;

        idle_line();
        for (int i = 0; i < 12 * BD; i++) line[i] = 1'b0;
        run(260);
        chk("break_word", snap[156][11:0], 12'hD00);
        chk("break_one_frame", ones(8, 0, 259), 1);

        bus.rx_ready = 1'b0;
        idle_line();
        put_frame(0, 8'h11, 0, 0, 0, 0);
        put_frame(160, 8'h22, 0, 0, 0, 0);
        run(340);
        chk("ovr_first", snap[156][8:0], 9'h111);
        chk("ovr_pulse", snap[316][12], 1);
        chk("ovr_pulse_pre", snap[315][12], 0);
        chk("ovr_pulse_post", snap[317][12], 0);
        chk("ovr_count", ones(12, 0, 339), 1);
        chk("ovr_held", snap[330][8:0], 9'h111);
        bus.rx_ready = 1'b1;
        @(negedge clk);
        chk("ovr_accept", cur()[8], 0);
        bus.rx_ready = 1'b0;

        idle_line();
        put_frame(0, 8'h5A, 0, 0, 0, 0);
        run(80);
        chk("arst_busy_before", snap[79][13], 1);
        arst = 1'b1;
        rx_in = 1'b1;
        @(negedge clk);
        chk("arst_outputs", cur(), 0);
        arst = 1'b0;
        repeat (20) @(negedge clk);
        bus.rx_ready = 1'b1;
        idle_line();
        put_frame(0, 8'h3C, 0, 0, 0, 0);
        run(200);
        chk("arst_next_word", snap[156][11:0], 12'h13C);

        rx_en = 1'b0;
        idle_line();
        put_frame(0, 8'h55, 0, 0, 0, 0);
        run(200);
        chk("dis_busy", ones(13, 0, 199), 0);
        chk("dis_valid", ones(8, 0, 199), 0);
        rx_en = 1'b1;

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
